// File: rtl/register_dump_reader.sv
// Walks a register-file address range and streams (addr, data) snapshots over valid/ready.
// First word 2 cycles after start; one word/cycle under ready; each stalled cycle adds one cycle.
module register_dump_reader #(
  parameter int D = 5,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [D-1:0] first_addr,
  input  logic [D-1:0] last_addr,
  output logic [D-1:0] rf_address,
  input  logic [W-1:0] rf_read_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [D-1:0] out_addr,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   cur_addr_q, cur_addr_d;
  logic [D-1:0]   end_addr_q, end_addr_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [D-1:0]   out_addr_q, out_addr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           out_free;

  // The output register can take a new word when empty or being emptied this cycle.
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    end_addr_d  = end_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_free) begin
          out_data_d  = rf_read_data;
          out_addr_d  = cur_addr_q;
          out_valid_d = 1'b1;
          if (cur_addr_q == end_addr_q) begin
            state_d = S_DRAIN;
          end else begin
            cur_addr_d = cur_addr_q + D'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      end_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      end_addr_q  <= end_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_address = cur_addr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_register_dump_reader.sv
// Directed and randomized dumps of a modelled register file, checked against an expected word list.
module tb_register_dump_reader;
  localparam int D     = 5;
  localparam int W     = 32;
  localparam int DEPTH = 32;

  logic         clk = 1'b0;
  logic         rst, start, abort, out_ready;
  logic [D-1:0] first_addr, last_addr, rf_address, out_addr;
  logic [W-1:0] rf_read_data, out_data;
  logic         out_valid, busy, done;
  logic [W-1:0] rf_mem [DEPTH];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign rf_read_data = rf_mem[rf_address];

  register_dump_reader #(.D(D), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .first_addr   (first_addr),
    .last_addr    (last_addr),
    .rf_address   (rf_address),
    .rf_read_data (rf_read_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_addr     (out_addr),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(out_valid),  32'd0);
    check({tag, "_data"},    out_data,        32'd0);
    check({tag, "_addr"},    32'(out_addr),   32'd0);
    check({tag, "_rfaddr"},  32'(rf_address), 32'd0);
    check({tag, "_busy"},    32'(busy),       32'd0);
    check({tag, "_done"},    32'(done),       32'd0);
  endtask

  // One complete dump: the expected stream is the address walk f, f+1, ... l (mod DEPTH)
  // with the register contents as they stand when the dump is launched.
  task automatic run_dump(input logic [D-1:0] f, input logic [D-1:0] l, input int stall_pct,
                          input bit hold2, input bit do_write, input bit poke_start);
    int           n;
    int           got;
    int           stalls;
    int           hold_cnt;
    int           done_cyc;
    bit           prev_stall;
    bit           written;
    logic [W-1:0] prev_data;
    logic [D-1:0] prev_addr;
    logic [D-1:0] a;
    logic [D-1:0] exp_addr[$];
    logic [W-1:0] exp_data[$];

    got = 0; stalls = 0; hold_cnt = 0; done_cyc = -1;
    prev_stall = 1'b0; written = 1'b0;
    prev_data = '0; prev_addr = '0;
    n = ((int'(l) - int'(f) + DEPTH) % DEPTH) + 1;
    for (int i = 0; i < n; i++) begin
      a = D'((int'(f) + i) % DEPTH);
      exp_addr.push_back(a);
      exp_data.push_back((do_write && a == D'(6)) ? 32'hCAFE_F00D : rf_mem[a]);
    end

    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    out_ready  = 1'b1;
    tick();
    start = 1'b0;
    check("c1_busy",   32'(busy),       32'd1);
    check("c1_rfaddr", 32'(rf_address), 32'(f));
    check("c1_valid",  32'(out_valid),  32'd0);

    for (int cyc = 1; cyc <= 4 * n + 200; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) check("busy_during_dump", 32'(busy), 32'd1);
      if (prev_stall) begin
        check("stall_data_stable", out_data, prev_data);
        check("stall_addr_stable", 32'(out_addr), 32'(prev_addr));
      end

      out_ready = 1'b1;
      if (hold2 && out_valid && out_addr == D'(2) && hold_cnt < 3) begin
        out_ready = 1'b0;
        hold_cnt++;
      end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        out_ready = 1'b0;
      end

      if (poke_start && cyc == 3) begin
        start      = 1'b1;
        first_addr = f + D'(5);
        last_addr  = f + D'(6);
      end else begin
        start = 1'b0;
      end

      if (out_valid) begin
        if (out_ready) begin
          if (got < n) begin
            check("word_addr",  32'(out_addr), 32'(exp_addr[got]));
            check("word_data",  out_data,      exp_data[got]);
            check("word_cycle", 32'(cyc),      32'(got + 2 + stalls));
          end else begin
            check("extra_word", 32'(got + 1), 32'(n));
          end
          got++;
        end else begin
          stalls++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;

      if (do_write && !written && out_valid && out_addr == D'(2)) begin
        rf_mem[2] = 32'hDEAD_BEEF;
        rf_mem[6] = 32'hCAFE_F00D;
        written   = 1'b1;
      end
      tick();
    end
    start = 1'b0;

    check("done_cycle",  32'(done_cyc),  32'(n + 2 + stalls));
    check("word_count",  32'(got),       32'(n));
    check("done_busy",   32'(busy),      32'd0);
    check("done_valid",  32'(out_valid), 32'd0);
    if (hold2) check("hold_cycles", 32'(hold_cnt), 32'd3);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("idle_busy",   32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    for (int i = 0; i < DEPTH; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Basic dump, continuous ready.
    run_dump(5'd0, 5'd4, 0, 1'b0, 1'b0, 1'b0);
    // Three stall cycles while address 2 is presented.
    run_dump(5'd0, 5'd4, 0, 1'b1, 1'b0, 1'b0);
    // Wrapping, single-word and full-range dumps.
    run_dump(5'd30, 5'd1, 0, 1'b0, 1'b0, 1'b0);
    run_dump(5'd3,  5'd3, 0, 1'b0, 1'b0, 1'b0);
    run_dump(5'd5,  5'd4, 0, 1'b0, 1'b0, 1'b0);
    // Writes during the dump: r[2] already captured, r[6] not yet.
    run_dump(5'd0, 5'd7, 0, 1'b0, 1'b1, 1'b0);

    // Abort while a word is waiting on a stalled consumer.
    first_addr = 5'd0; last_addr = 5'd4; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("abort_pre_valid", 32'(out_valid), 32'd1);
    check("abort_pre_addr",  32'(out_addr),  32'd0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_done",  32'(done),      32'd0);
    run_dump(5'd3, 5'd9, 0, 1'b0, 1'b0, 1'b0);

    // Reset mid-dump with a competing start.
    first_addr = 5'd0; last_addr = 5'd9; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1; start = 1'b1; first_addr = 5'd7; last_addr = 5'd7;
    tick();
    rst = 1'b0; start = 1'b0;
    check_reset_outputs("rst_mid");
    tick();
    check("rst_start_ignored_busy",   32'(busy),       32'd0);
    check("rst_start_ignored_rfaddr", 32'(rf_address), 32'd0);
    tick();
    check("rst_idle_valid", 32'(out_valid), 32'd0);

    // Start pulsed while busy must not disturb the stream.
    run_dump(5'd10, 5'd20, 0, 1'b0, 1'b0, 1'b1);

    // Random contents, ranges and backpressure.
    for (int i = 0; i < DEPTH; i++) rf_mem[i] = $urandom;
    for (int t = 0; t < 8; t++) begin
      run_dump(D'($urandom_range(DEPTH - 1)), D'($urandom_range(DEPTH - 1)), 30, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/register_dump_reader.md
# register_dump_reader

Sequential read-out engine for the processor register file. It drives the register file's combinational read address itself. On a start command it walks a programmable address range, captures each register's value, and streams the values as (address, data) words over a valid/ready interface. It sits beside the register file as a debug and verification port, for state dumps to a host or scan logic, and never uses the write port.

## Interface
- D, 5, address width; the register file has 2^D entries
- W, 32, data width
- clk  in  1  rising-edge clock shared with the register file
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- abort  in  1  cancels a dump in progress; no done pulse is produced
- first_addr  in  D  first register read; sampled with start
- last_addr  in  D  last register read; sampled with start
- rf_address  out  D  read address to the register file's spare read port
- rf_read_data  in  W  combinational read data for rf_address
- out_valid  out  1  out_data/out_addr hold a word
- out_ready  in  1  consumer accepts the word when high together with out_valid
- out_data  out  W  captured register value
- out_addr  out  D  address the value came from
- busy  out  1  dump in progress, covering READ and DRAIN
- done  out  1  one-cycle pulse after the last word is accepted

## Operation
- The FSM has four states: IDLE, READ, DRAIN and DONE.
- IDLE:
  - start=1 latches cur_addr=first_addr and end_addr=last_addr, then moves to READ.
  - start is ignored in every other state.
- READ:
  - rf_address=cur_addr.
  - The output register is free when !out_valid or (out_valid & out_ready).
  - When free: out_data<=rf_read_data, out_addr<=cur_addr, out_valid<=1.
  - If cur_addr==end_addr the FSM moves to DRAIN; otherwise cur_addr<=cur_addr+1, mod 2^D.
  - When not free, cur_addr holds and nothing is captured.
- DRAIN:
  - On out_valid & out_ready: out_valid<=0 and the FSM moves to DONE.
- DONE:
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
  - start is accepted in the cycle after DONE.
- Word count is N=((end_addr-first_addr) mod 2^D)+1.
  - first==last gives 1 word.
  - last==first-1 gives the full 2^D words.
  - last<first wraps through 2^D-1 to 0.
- Each value is a snapshot taken at its capture edge. A write-port update to an already captured address is not re-read.
- While out_valid=1 and out_ready=0, out_data and out_addr are stable.
- abort=1 in READ or DRAIN:
  - out_valid<=0 and the FSM moves to IDLE at the next edge.
  - A word pending in that cycle is dropped even if out_ready=1.
  - No done pulse is produced.
  - abort has no effect in IDLE or DONE.
- rst has priority over abort and start. rst mid-dump discards all state.
- Reset values:
  - state=IDLE
  - rf_address=0
  - out_valid=0
  - out_data=0
  - out_addr=0
  - busy=0
  - done=0
- In IDLE and DONE, rf_address holds its last value.

## Timing
- The clock edge that samples start ends cycle 0.
- With out_ready held high:
  - Cycle 1: READ, rf_address=first_addr.
  - Cycle 2: first out_valid, carrying first_addr.
  - One word per cycle after that.
  - Last word valid in cycle N+1; DONE (done=1, busy=0) in cycle N+2.
- busy=1 in cycles 1..N+1.
- Throughput is 1 word/cycle under continuous ready, with no bubble at the start of the stream.
- Backpressure: each cycle with out_ready=0 while out_valid=1 adds exactly one cycle of latency. No word is lost or duplicated.
- Latency from the abort edge to out_valid=0 and busy=0 is one edge.

## Test plan
- Preload the register file with r[i]=32'h1000_0000+i. Pulse start with first=0, last=4 and hold out_ready=1.
  - Required: words (0,10000000)..(4,10000004) in cycles 2..6.
  - Required: done pulses in cycle 7 only.
- Run the same dump with out_ready=0 for 3 cycles while address 2 is presented.
  - Required: out_data and out_addr hold 2/10000002 for those cycles.
  - Required: no address is skipped or repeated; done is delayed by 3 cycles.
- Dump first=30, last=1.
  - Required: address order 30, 31, 0, 1 with 4 words.
  - Required: first=3, last=3 yields exactly 1 word.
  - Required: first=5, last=4 yields 32 words.
- After address 2 is captured, write 32'hDEAD_BEEF to r[2] and 32'hCAFE_F00D to r[6] during the dump.
  - Required: the stream reports the old r[2] and the new r[6].
- Assert abort in the cycle after word 1 is valid (out_ready=0).
  - Required: out_valid=0 and busy=0 after one edge; no done pulse.
  - Required: a new start is accepted the next cycle and is correct.
- Assert rst mid-dump, with start=1 in the same cycle.
  - Required: all outputs return to reset values; the start is ignored.
  - Required: start pulsed while busy is ignored.
